// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART transmit arbiter: FSM states, grant codes and
// the link timing constants used by uart_send.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ECHO = 2'd1,
    ST_MSG  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ECHO = 2'b01;
  localparam logic [1:0] GNT_MSG  = 2'b10;

  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  function automatic logic [1:0] grant_of(input state_t s);
    case (s)
      ST_ECHO: return GNT_ECHO;
      ST_MSG:  return GNT_MSG;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, show-ahead head; full write without a pop is dropped
// and flagged on o_overflow the next cycle, a simultaneous pop makes room.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_dout     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;
  assign w_pop      = i_rd_en && !o_empty;
  assign w_push     = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr_en && o_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of uart_send between echo FIFO and locked message packets;
// a grant starts one cycle after the request is seen in IDLE, tx_ready stalls both.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_echo_valid,
  input  logic [7:0] i_echo_data,
  output logic       o_echo_overflow,
  input  logic       i_msg_valid,
  input  logic [7:0] i_msg_data,
  input  logic       i_msg_last,
  output logic       o_msg_ready,
  output logic       o_msg_abort,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic [1:0] o_grant
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [1:0]    r_last_grant;
  logic [TW-1:0] r_to_cnt;
  logic          r_msg_abort;
  logic          w_pop;
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_echo_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_echo_valid),
    .i_din      (i_echo_data),
    .i_rd_en    (w_pop),
    .o_dout     (w_fifo_dout),
    .o_full     (),
    .o_empty    (w_fifo_empty),
    .o_overflow (o_echo_overflow)
  );

  assign o_grant     = grant_of(r_state);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_msg_abort = r_msg_abort;

  // The granted source is passed straight through so a stalled byte stays put.
  always_comb begin
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    o_msg_ready = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_ECHO: begin
        o_tx_valid = 1'b1;
        o_tx_data  = w_fifo_dout;
        w_pop      = i_tx_ready;
      end
      ST_MSG: begin
        o_tx_valid  = i_msg_valid;
        o_tx_data   = i_msg_data;
        o_msg_ready = i_tx_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_MSG;
      r_to_cnt     <= '0;
      r_msg_abort  <= 1'b0;
    end else begin
      r_msg_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (!w_fifo_empty && (!i_msg_valid || r_last_grant == GNT_MSG)) begin
            r_state      <= ST_ECHO;
            r_last_grant <= GNT_ECHO;
          end else if (i_msg_valid) begin
            r_state      <= ST_MSG;
            r_last_grant <= GNT_MSG;
          end
        end
        ST_ECHO: begin
          if (i_tx_ready) r_state <= ST_IDLE;
        end
        ST_MSG: begin
          // Packet holds the lock until its last byte or a stall timeout.
          if (i_msg_valid) begin
            r_to_cnt <= '0;
            if (i_tx_ready && i_msg_last) r_state <= ST_IDLE;
          end else if (r_to_cnt == TO_MAX) begin
            r_to_cnt    <= '0;
            r_state     <= ST_IDLE;
            r_msg_abort <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle vector tables plus hand-built sequences,
// every transmitted byte checked against per-source expectation queues.
module tb_uart_tx_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_echo_valid;
  logic [7:0] i_echo_data;
  logic       o_echo_overflow;
  logic       i_msg_valid;
  logic [7:0] i_msg_data;
  logic       i_msg_last;
  logic       o_msg_ready;
  logic       o_msg_abort;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready;
  logic       o_busy;
  logic [1:0] o_grant;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_echo_valid    (i_echo_valid),
    .i_echo_data     (i_echo_data),
    .o_echo_overflow (o_echo_overflow),
    .i_msg_valid     (i_msg_valid),
    .i_msg_data      (i_msg_data),
    .i_msg_last      (i_msg_last),
    .o_msg_ready     (o_msg_ready),
    .o_msg_abort     (o_msg_abort),
    .o_tx_valid      (o_tx_valid),
    .o_tx_data       (o_tx_data),
    .i_tx_ready      (i_tx_ready),
    .o_busy          (o_busy),
    .o_grant         (o_grant)
  );

  typedef struct {
    logic       ev;
    logic [7:0] ed;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic       mnew;
    logic       rdy;
    logic       xv;
    logic [7:0] xd;
    logic       mr;
    logic [1:0] gnt;
    logic       bsy;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] echo_q[$];
  logic [7:0] msg_q[$];
  bit         sb_en = 1'b0;
  vec_t       tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ev, input logic [7:0] ed, input logic mv,
                              input logic [7:0] md, input logic ml, input logic mnew,
                              input logic rdy, input logic xv, input logic [7:0] xd,
                              input logic mr, input logic [1:0] gnt, input logic bsy);
    vec_t v;
    v.ev = ev; v.ed = ed; v.mv = mv; v.md = md; v.ml = ml; v.mnew = mnew;
    v.rdy = rdy; v.xv = xv; v.xd = xd; v.mr = mr; v.gnt = gnt; v.bsy = bsy;
    return v;
  endfunction

  // Scoreboard: each accepted byte is matched against the queue of its granted source.
  always @(negedge i_clk) begin
    if (sb_en && o_tx_valid && i_tx_ready) begin
      if (o_grant == 2'b01) begin
        if (echo_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_echo_extra: unexpected echo byte %0h", o_tx_data);
        end else check("sb_echo_data", 32'(o_tx_data), 32'(echo_q.pop_front()));
      end else if (o_grant == 2'b10) begin
        if (msg_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_msg_extra: unexpected message byte %0h", o_tx_data);
        end else check("sb_msg_data", 32'(o_tx_data), 32'(msg_q.pop_front()));
      end else begin
        n_tests++; n_fail++;
        $display("FAIL sb_grant: tx_valid with grant %0h", o_grant);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_echo_valid = 1'b0; i_echo_data = 8'h00;
    i_msg_valid = 1'b0; i_msg_data = 8'h00; i_msg_last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_tx_ready = 1'b0;
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    echo_q.delete();
    msg_q.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int k = 0; k < budget && (echo_q.size() + msg_q.size()) != 0; k++) step();
    check(name, echo_q.size() + msg_q.size(), 0);
    idle_inputs();
    step();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_tx_valid"}, 32'(o_tx_valid), 0);
    check({pfx, "_tx_data"}, 32'(o_tx_data), 0);
    check({pfx, "_msg_ready"}, 32'(o_msg_ready), 0);
    check({pfx, "_overflow"}, 32'(o_echo_overflow), 0);
    check({pfx, "_abort"}, 32'(o_msg_abort), 0);
    check({pfx, "_busy"}, 32'(o_busy), 0);
    check({pfx, "_grant"}, 32'(o_grant), 0);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      i_echo_valid = tbl[i].ev; i_echo_data = tbl[i].ed;
      i_msg_valid = tbl[i].mv; i_msg_data = tbl[i].md; i_msg_last = tbl[i].ml;
      i_tx_ready = tbl[i].rdy;
      if (tbl[i].ev) echo_q.push_back(tbl[i].ed);
      if (tbl[i].mnew) msg_q.push_back(tbl[i].md);
      @(negedge i_clk);
      check($sformatf("vec%0d_tx_valid", i), 32'(o_tx_valid), 32'(tbl[i].xv));
      check($sformatf("vec%0d_tx_data", i), 32'(o_tx_data), 32'(tbl[i].xd));
      check($sformatf("vec%0d_msg_ready", i), 32'(o_msg_ready), 32'(tbl[i].mr));
      check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(tbl[i].gnt));
      check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(tbl[i].bsy));
      check($sformatf("vec%0d_overflow", i), 32'(o_echo_overflow), 0);
      check($sformatf("vec%0d_abort", i), 32'(o_msg_abort), 0);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] helo [4];
    helo[0] = 8'h48; helo[1] = 8'h45; helo[2] = 8'h4C; helo[3] = 8'h4F;

    //        ev  ed     mv  md     ml  new rdy xv  xd     mr  gnt    bsy
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[1]  = mk(1, 8'h41, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[2]  = mk(1, 8'h42, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[3]  = mk(1, 8'h43, 0, 8'h00, 0, 0, 1, 1, 8'h41, 0, 2'b01, 1);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 8'h42, 0, 2'b01, 1);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 8'h43, 0, 2'b01, 1);
    tbl[8]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    // Round-robin after reset: echo wins the first tie, message the next.
    tbl[9]  = mk(1, 8'h55, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[10] = mk(0, 8'h00, 1, 8'h4D, 1, 1, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[11] = mk(1, 8'h56, 1, 8'h4D, 1, 0, 1, 1, 8'h55, 0, 2'b01, 1);
    tbl[12] = mk(0, 8'h00, 1, 8'h4D, 1, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[13] = mk(0, 8'h00, 1, 8'h4D, 1, 0, 0, 1, 8'h4D, 0, 2'b10, 1);
    tbl[14] = mk(0, 8'h00, 1, 8'h4D, 1, 0, 1, 1, 8'h4D, 1, 2'b10, 1);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h56, 0, 2'b01, 1);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 8'h56, 0, 2'b01, 1);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 2'b00, 0);

    i_rst = 1'b1;
    i_tx_ready = 1'b0;
    idle_inputs();
    sb_en = 1'b1;
    do_reset();
    @(negedge i_clk);
    check_all_zero("reset");
    step();

    run_table(0, 9);
    check("echo_only_drain", echo_q.size(), 0);
    do_reset();
    run_table(9, 19);
    check("rr_drain", echo_q.size() + msg_q.size(), 0);

    // Packet lock: echo bytes arriving mid-packet wait for the last byte.
    i_tx_ready = 1'b1;
    i_msg_valid = 1'b1; i_msg_data = helo[0]; i_msg_last = 1'b0;
    msg_q.push_back(helo[0]);
    @(negedge i_clk);
    check("lock_req_idle", 32'(o_grant), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      i_msg_data = helo[i];
      i_msg_last = (i == 3);
      if (i > 0) msg_q.push_back(helo[i]);
      i_echo_valid = (i == 1 || i == 2);
      i_echo_data = 8'h60 + 8'(i);
      if (i_echo_valid) echo_q.push_back(i_echo_data);
      @(negedge i_clk);
      check($sformatf("lock_b%0d_grant", i), 32'(o_grant), 32'b10);
      check($sformatf("lock_b%0d_ready", i), 32'(o_msg_ready), 1);
      step();
    end
    idle_inputs();
    @(negedge i_clk);
    check("lock_gap", 32'(o_grant), 0);
    step();
    @(negedge i_clk);
    check("lock_echo1", 32'(o_grant), 32'b01);
    step();
    @(negedge i_clk);
    check("lock_gap2", 32'(o_grant), 0);
    step();
    @(negedge i_clk);
    check("lock_echo2", 32'(o_grant), 32'b01);
    step();
    wait_drain("lock_drain", 20);

    // Overflow: five writes into a four-deep FIFO with the transmitter stalled.
    i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_echo_valid = 1'b1;
      i_echo_data = 8'h71 + 8'(i);
      if (i < 4) echo_q.push_back(i_echo_data);
      @(negedge i_clk);
      check($sformatf("ovf_none%0d", i), 32'(o_echo_overflow), 0);
      step();
    end
    idle_inputs();
    @(negedge i_clk);
    check("ovf_pulse", 32'(o_echo_overflow), 1);
    step();
    @(negedge i_clk);
    check("ovf_single", 32'(o_echo_overflow), 0);
    i_tx_ready = 1'b1;
    step();
    wait_drain("ovf_drain", 40);

    // Stall timeout: one non-last byte, then msg_valid held low.
    step();
    i_msg_valid = 1'b1; i_msg_data = 8'h41; i_msg_last = 1'b0;
    msg_q.push_back(8'h41);
    @(negedge i_clk);
    check("to_req_idle", 32'(o_grant), 0);
    step();
    i_echo_valid = 1'b1; i_echo_data = 8'h7E;
    echo_q.push_back(8'h7E);
    @(negedge i_clk);
    check("to_first", 32'(o_grant), 32'b10);
    step();
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      check($sformatf("to_wait%0d_grant", k), 32'(o_grant), 32'b10);
      check($sformatf("to_wait%0d_abort", k), 32'(o_msg_abort), 0);
      step();
    end
    @(negedge i_clk);
    check("to_idle", 32'(o_grant), 0);
    check("to_abort", 32'(o_msg_abort), 1);
    step();
    @(negedge i_clk);
    check("to_abort_once", 32'(o_msg_abort), 0);
    check("to_echo_next", 32'(o_grant), 32'b01);
    step();
    wait_drain("to_drain", 20);

    // Reset mid-packet with three bytes queued in the echo FIFO.
    step();
    i_msg_valid = 1'b1; i_msg_data = 8'h57; i_msg_last = 1'b0;
    msg_q.push_back(8'h57);
    i_echo_valid = 1'b1; i_echo_data = 8'h81;
    echo_q.push_back(8'h81);
    step();
    i_echo_data = 8'h82;
    echo_q.push_back(8'h82);
    @(negedge i_clk);
    check("rst_b1_grant", 32'(o_grant), 32'b10);
    step();
    i_msg_data = 8'h58;
    msg_q.push_back(8'h58);
    i_echo_data = 8'h83;
    echo_q.push_back(8'h83);
    i_tx_ready = 1'b0;
    @(negedge i_clk);
    check("rst_b2_grant", 32'(o_grant), 32'b10);
    step();
    i_echo_valid = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    idle_inputs();
    i_tx_ready = 1'b1;
    echo_q.delete();
    msg_q.delete();
    @(negedge i_clk);
    check_all_zero("rst_mid");
    step();
    @(negedge i_clk);
    check("rst_fifo_empty", 32'(o_tx_valid), 0);
    check("rst_no_abort", 32'(o_msg_abort), 0);
    step();
    i_echo_valid = 1'b1; i_echo_data = 8'h91;
    echo_q.push_back(8'h91);
    step();
    i_echo_valid = 1'b0;
    i_msg_valid = 1'b1; i_msg_data = 8'h59; i_msg_last = 1'b1;
    msg_q.push_back(8'h59);
    @(negedge i_clk);
    check("rst_tie_idle", 32'(o_grant), 0);
    step();
    @(negedge i_clk);
    check("rst_tie_echo", 32'(o_grant), 32'b01);
    step();
    step();
    @(negedge i_clk);
    check("rst_then_msg", 32'(o_grant), 32'b10);
    step();
    idle_inputs();
    wait_drain("rst_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
